// File: rtl/sram_lsu_requester.sv
// Load/store requester: turns LSU byte/half/word accesses into one-shot
// SRAM controller strobes with lane masks, replication, extension and timeout.
module sram_lsu_requester #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_lsu_ld,
    input  logic        i_lsu_st,
    input  logic [31:0] i_lsu_addr,
    input  logic [2:0]  i_lsu_funct3,
    input  logic [31:0] i_lsu_wdata,
    output logic        o_lsu_ready,
    output logic        o_lsu_done,
    output logic        o_lsu_err,
    output logic [31:0] o_lsu_rdata,
    output logic [17:0] o_ADDR,
    output logic [31:0] o_WDATA,
    output logic [3:0]  o_BMASK,
    output logic        o_WREN,
    output logic        o_RDEN,
    input  logic [31:0] i_RDATA,
    input  logic        i_ACK
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [1:0]  r_lane;
    logic [2:0]  r_funct3;
    logic        r_st;
    logic [7:0]  r_cnt;
    logic        r_err;
    logic [31:0] r_rdata;
    logic [17:0] r_ADDR;
    logic [31:0] r_WDATA;
    logic [3:0]  r_BMASK;

    logic        w_req;
    logic        w_illegal;
    logic        w_timeout;
    logic [3:0]  w_bmask;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ld_data;

    assign w_req     = i_lsu_ld | i_lsu_st;
    assign w_timeout = (r_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_illegal = i_lsu_ld & i_lsu_st;
        case (i_lsu_funct3)
            3'b000: ;
            3'b100: if (i_lsu_st) w_illegal = 1'b1;
            3'b001: if (i_lsu_addr[0]) w_illegal = 1'b1;
            3'b101: if (i_lsu_st || i_lsu_addr[0]) w_illegal = 1'b1;
            3'b010: if (i_lsu_addr[1:0] != 2'b00) w_illegal = 1'b1;
            default: w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_bmask = 4'b1111;
        w_wdata = i_lsu_wdata;
        case (i_lsu_funct3[1:0])
            2'b00: begin
                w_bmask = 4'b0001 << i_lsu_addr[1:0];
                w_wdata = {4{i_lsu_wdata[7:0]}};
            end
            2'b01: begin
                w_bmask = 4'b0011 << i_lsu_addr[1:0];
                w_wdata = {2{i_lsu_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Lane selection uses the address captured at acceptance
    always_comb begin
        w_byte = i_RDATA[7:0];
        case (r_lane)
            2'd1: w_byte = i_RDATA[15:8];
            2'd2: w_byte = i_RDATA[23:16];
            2'd3: w_byte = i_RDATA[31:24];
            default: ;
        endcase
        w_half = r_lane[1] ? i_RDATA[31:16] : i_RDATA[15:0];
        w_ld_data = i_RDATA;
        case (r_funct3)
            3'b000: w_ld_data = {{24{w_byte[7]}}, w_byte};
            3'b100: w_ld_data = {24'd0, w_byte};
            3'b001: w_ld_data = {{16{w_half[15]}}, w_half};
            3'b101: w_ld_data = {16'd0, w_half};
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_req) w_next = w_illegal ? S_DONE : S_REQ;
            S_REQ:  w_next = S_WAIT;
            S_WAIT: if (i_ACK || w_timeout) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_lsu_ready = (r_state == S_IDLE);
        o_lsu_done  = (r_state == S_DONE);
        o_lsu_err   = (r_state == S_DONE) & r_err;
        o_WREN      = (r_state == S_REQ) & r_st;
        o_RDEN      = (r_state == S_REQ) & ~r_st;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_lane   <= 2'd0;
            r_funct3 <= 3'd0;
            r_st     <= 1'b0;
            r_cnt    <= 8'd0;
            r_err    <= 1'b0;
            r_rdata  <= 32'd0;
            r_ADDR   <= 18'd0;
            r_WDATA  <= 32'd0;
            r_BMASK  <= 4'd0;
        end else begin
            if (r_state == S_IDLE && w_req) begin
                r_err <= w_illegal;
                if (!w_illegal) begin
                    r_lane   <= i_lsu_addr[1:0];
                    r_funct3 <= i_lsu_funct3;
                    r_st     <= i_lsu_st;
                    r_ADDR   <= {i_lsu_addr[18:2], 1'b0};
                    r_WDATA  <= w_wdata;
                    r_BMASK  <= w_bmask;
                end
            end
            if (r_state == S_WAIT) begin
                if (!i_ACK) r_cnt <= r_cnt + 8'd1;
                r_err <= ~i_ACK & w_timeout;
                if (i_ACK && !r_st) r_rdata <= w_ld_data;
            end else begin
                r_cnt <= 8'd0;
            end
            if (r_state == S_DONE) r_err <= 1'b0;
        end
    end

    assign o_lsu_rdata = r_rdata;
    assign o_ADDR      = r_ADDR;
    assign o_WDATA     = r_WDATA;
    assign o_BMASK     = r_BMASK;

endmodule

// File: tb/tb_sram_lsu_requester.sv
// Directed bench for sram_lsu_requester: stores, loads, illegal
// requests, timeout, ack/timeout race and reset abort.
module tb_sram_lsu_requester;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld, st;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] wdata;
    logic        ready, done, err;
    logic [31:0] rdata;
    logic [17:0] sADDR;
    logic [31:0] sWDATA;
    logic [3:0]  sBMASK;
    logic        sWREN, sRDEN;
    logic [31:0] sRDATA;
    logic        sACK;

    int tests = 0;
    int fails = 0;

    sram_lsu_requester #(.TIMEOUT_CYCLES(4)) dut (
        .i_clk(clk),
        .i_reset(rst),
        .i_lsu_ld(ld),
        .i_lsu_st(st),
        .i_lsu_addr(addr),
        .i_lsu_funct3(f3),
        .i_lsu_wdata(wdata),
        .o_lsu_ready(ready),
        .o_lsu_done(done),
        .o_lsu_err(err),
        .o_lsu_rdata(rdata),
        .o_ADDR(sADDR),
        .o_WDATA(sWDATA),
        .o_BMASK(sBMASK),
        .o_WREN(sWREN),
        .o_RDEN(sRDEN),
        .i_RDATA(sRDATA),
        .i_ACK(sACK)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge, then drop it
    task automatic issue(input logic l, input logic s, input logic [31:0] a,
                         input logic [2:0] f, input logic [31:0] d);
        ld = l; st = s; addr = a; f3 = f; wdata = d;
        step();
        ld = 0; st = 0; addr = 0; f3 = 0; wdata = 0;
    endtask

    // From REQ: n idle WAIT cycles, then a WAIT cycle with ack; ends in DONE
    task automatic ack_after(input int n, input logic [31:0] rd);
        step();
        for (int i = 0; i < n; i++) step();
        sACK = 1; sRDATA = rd;
        step();
        sACK = 0; sRDATA = 0;
    endtask

    initial begin
        rst = 1; ld = 0; st = 0; addr = 0; f3 = 0; wdata = 0;
        sRDATA = 0; sACK = 0;
        step(); step();
        rst = 0;
        chk("rst_ready", {31'd0, ready}, 1);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_addr", {14'd0, sADDR}, 0);
        chk("rst_wdata", sWDATA, 0);
        chk("rst_strb", {28'd0, sBMASK, sWREN, sRDEN, 2'b00}, 0);

        issue(0, 1, 32'h0000_0104, 3'b010, 32'hDEAD_BEEF);
        chk("sw_wren", {31'd0, sWREN}, 1);
        chk("sw_rden", {31'd0, sRDEN}, 0);
        chk("sw_addr", {14'd0, sADDR}, 32'h82);
        chk("sw_mask", {28'd0, sBMASK}, 4'hF);
        chk("sw_wdata", sWDATA, 32'hDEAD_BEEF);
        chk("sw_ready", {31'd0, ready}, 0);
        step();
        chk("sw_wren_1cyc", {31'd0, sWREN}, 0);
        chk("sw_addr_hold", {14'd0, sADDR}, 32'h82);
        sACK = 1;
        step();
        sACK = 0;
        chk("sw_done", {30'd0, done, err}, 2'b10);
        step();
        chk("sw_idle", {30'd0, ready, done}, 2'b10);
        chk("sw_rdata_keep", rdata, 0);

        issue(1, 0, 32'h0000_0013, 3'b000, 0);
        chk("lb_rden", {30'd0, sRDEN, sWREN}, 2'b10);
        chk("lb_mask", {28'd0, sBMASK}, 4'b1000);
        chk("lb_addr", {14'd0, sADDR}, 32'h8);
        ack_after(1, 32'h80FF_1234);
        chk("lb_done", {30'd0, done, err}, 2'b10);
        chk("lb_rdata", rdata, 32'hFFFF_FF80);
        step();

        issue(1, 0, 32'h0000_0013, 3'b100, 0);
        ack_after(1, 32'h80FF_1234);
        chk("lbu_rdata", rdata, 32'h0000_0080);
        step();

        issue(0, 1, 32'h0000_0006, 3'b001, 32'h0000_ABCD);
        chk("sh_wdata", sWDATA, 32'hABCD_ABCD);
        chk("sh_mask", {28'd0, sBMASK}, 4'b1100);
        ack_after(0, 0);
        chk("sh_rdata_keep", rdata, 32'h0000_0080);
        step();

        issue(1, 0, 32'h0000_0006, 3'b101, 0);
        chk("lhu_mask", {28'd0, sBMASK}, 4'b1100);
        ack_after(1, 32'hABCD_0000);
        chk("lhu_rdata", rdata, 32'h0000_ABCD);
        step();

        issue(1, 0, 32'h0000_0002, 3'b010, 0);
        chk("lw_mis_strb", {30'd0, sWREN, sRDEN}, 0);
        chk("lw_mis_done", {30'd0, done, err}, 2'b11);
        step();
        chk("lw_mis_idle", {31'd0, ready}, 1);

        issue(1, 1, 32'h0000_0000, 3'b010, 0);
        chk("ldst_done", {30'd0, done, err}, 2'b11);
        step();

        issue(0, 1, 32'h0000_0000, 3'b100, 0);
        chk("sbu_illegal", {30'd0, done, err}, 2'b11);
        step();

        sACK = 1; sRDATA = 32'h5555_5555;
        step();
        sACK = 0; sRDATA = 0;
        chk("ack_idle_ign", {29'd0, ready, done, err}, 3'b100);
        chk("ack_idle_rd", rdata, 32'h0000_ABCD);

        issue(1, 0, 32'h0000_0000, 3'b010, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("to_wait", {31'd0, done}, 0);
        end
        step();
        chk("to_done", {30'd0, done, err}, 2'b11);
        chk("to_rdata", rdata, 32'h0000_ABCD);
        step();

        issue(1, 0, 32'h0000_0000, 3'b010, 0);
        ack_after(3, 32'h1234_5678);
        chk("race_done", {30'd0, done, err}, 2'b10);
        chk("race_rdata", rdata, 32'h1234_5678);
        step();

        issue(1, 0, 32'h0000_0104, 3'b010, 0);
        step();
        rst = 1;
        step();
        rst = 0; sACK = 1; sRDATA = 32'hFFFF_FFFF;
        step();
        sACK = 0; sRDATA = 0;
        chk("rabort_ctl", {29'd0, ready, done, err}, 3'b100);
        chk("rabort_rd", rdata, 0);
        chk("rabort_addr", {14'd0, sADDR}, 0);
        chk("rabort_strb", {26'd0, sBMASK, sWREN, sRDEN}, 0);
        chk("rabort_wd", sWDATA, 0);
        step();
        chk("rabort_nodone", {31'd0, done}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
